dpram_param_sync: RTL and testbench
===================================

// Module: dpram_param_sync
// PURPOSE
//  Parametrised single-clock dual-port RAM: one write port, one read port, generalised width and depth.
//  Adds per-lane write enables, a selectable read latency, a read-during-write mode, a read-valid strobe,
//  a collision flag and an optional post-reset clear sequencer.
//  Used as the memory-block primitive in mem-enabled architectures, replacing fixed-size dual-port RAMs.
// PARAMETERS
//  DATA_WIDTH  8  word width in bits; must be a multiple of BYTE_WIDTH
//  ADDR_WIDTH  7  address bits; DEPTH = 2**ADDR_WIDTH words
//  BYTE_WIDTH  8  write-lane width; LANES = DATA_WIDTH/BYTE_WIDTH
//  OUT_REG     0  0: read latency 1 cycle; 1: extra output register, read latency 2 cycles
//  RDW_MODE    0  same-address read during write: 0 = old data, 1 = new data (write-through, lane-merged)
//  INIT_CLEAR  1  1: zero every word after reset; 0: memory contents not touched by reset
// PORTS
//  clk       in   1           single clock; all state updates on posedge
//  rst       in   1           synchronous active-high reset
//  wen       in   1           write enable
//  waddr     in   ADDR_WIDTH  write address
//  data_in   in   DATA_WIDTH  write data
//  be        in   LANES       lane write enables; be[i] covers data bits i*BYTE_WIDTH .. (i+1)*BYTE_WIDTH-1
//  ren       in   1           read enable
//  raddr     in   ADDR_WIDTH  read address
//  data_out  out  DATA_WIDTH  read data
//  rvalid    out  1           one-cycle strobe, data_out holds the result of an accepted read
//  collision out  1           high together with rvalid when that read hit the same-cycle write address
//  busy      out  1           clear sequence running; all requests ignored
// BEHAVIOUR
//  - Reset (clk edge with rst=1): data_out=0, rvalid=0, collision=0, pipeline stages=0, clear counter=0.
//    busy=1 if INIT_CLEAR=1, else 0. rst has priority over every other input.
//  - Clear FSM (INIT_CLEAR=1): states IDLE, CLEAR. rst -> CLEAR, counter=0. In CLEAR each cycle writes 0 to
//    word[counter], counter++. After writing DEPTH-1 -> IDLE. busy=1 in CLEAR: exactly DEPTH cycles after rst falls.
//    rst mid-clear restarts the clear from address 0. INIT_CLEAR=0: FSM stays in IDLE, busy tied 0.
//  - Requests are accepted only when busy=0. wen/ren while busy: ignored, no memory change, no rvalid.
//  - Write: accepted wen -> at the edge, for each lane i with be[i]=1, word[waddr] lane i <= data_in lane i.
//    Other lanes keep their value. wen with be=0: no change.
//  - Read: accepted ren samples raddr at edge N.
//    OUT_REG=0: data_out/rvalid valid after edge N. OUT_REG=1: after edge N+1.
//    Back-to-back reads give one result per cycle. rvalid is high 1 cycle per accepted read.
//  - data_out holds its last value when no read completes; it is never cleared except by rst.
//  - Collision: accepted wen & ren with waddr==raddr in the same cycle.
//    RDW_MODE=0 returns the pre-write word. RDW_MODE=1 returns data_in on lanes with be=1, old word elsewhere.
//    collision is asserted aligned with that read's rvalid. Different addresses never collide.
//  - Address widths are exact; no out-of-range addresses exist. Elaboration error if DATA_WIDTH % BYTE_WIDTH != 0.
// TESTING
//  1. Defaults, INIT_CLEAR=1, rst 1 cycle.
//     -> busy high exactly 128 cycles after rst falls; then reads of all 128 addresses return 8'h00.
//  2. Write 8'hA5 to addr 5, next cycle ren at addr 5.
//     -> data_out=8'hA5 with rvalid 1 edge after the read (OUT_REG=0), 2 edges after (OUT_REG=1).
//  3. Addr 9 holds 8'h11; same cycle wen 8'h22 to 9 and ren at 9.
//     -> RDW_MODE=0: 8'h11; RDW_MODE=1: 8'h22; collision=1 with rvalid in both. Subsequent read of 9 returns 8'h22.
//  4. DATA_WIDTH=32: write all lanes 8'hFF to addr 3, then write lanes 8'h12,8'h34,8'h56,8'h78 with be lanes 0,2 only.
//     -> read of addr 3 gives lanes 8'h12,8'hFF,8'h56,8'hFF.
//  5. rst pulsed 50 cycles into a clear, ren/wen driven during busy.
//     -> busy stays high, clear restarts, busy falls 128 cycles after rst falls; no rvalid, no memory change.
//  6. Read 8'h3C, then 10 idle cycles, then rst.
//     -> data_out holds 8'h3C, rvalid=0 while idle; after rst data_out=0, rvalid=0, collision=0.

Source files
------------

// File: rtl/dpram_param_sync.sv
// Single-clock dual-port RAM with lane write enables, selectable read latency,
// read-during-write mode, read-valid/collision strobes and a post-reset clear.
module dpram_param_sync #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int BYTE_WIDTH = 8,
  parameter int OUT_REG    = 0,
  parameter int RDW_MODE   = 0,
  parameter int INIT_CLEAR = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wen,
  input  logic [ADDR_WIDTH-1:0]            waddr,
  input  logic [DATA_WIDTH-1:0]            data_in,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be,
  input  logic                             ren,
  input  logic [ADDR_WIDTH-1:0]            raddr,
  output logic [DATA_WIDTH-1:0]            data_out,
  output logic                             rvalid,
  output logic                             collision,
  output logic                             busy
);

  localparam int LANES = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    wr_acc;
  logic                    rd_acc;
  logic                    hit;
  logic                    clearing;
  logic [DATA_WIDTH-1:0]   old_word;
  logic [DATA_WIDTH-1:0]   rd_word;

  logic [DATA_WIDTH-1:0]   s1_data;
  logic                    s1_valid;
  logic                    s1_coll;

  assign clearing = (state == CLEAR);
  assign wr_acc   = wen & ~busy;
  assign rd_acc   = ren & ~busy;
  assign hit      = wr_acc & rd_acc & (waddr == raddr);
  assign old_word = mem[raddr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= (INIT_CLEAR != 0) ? CLEAR : IDLE;
      clr_cnt <= '0;
      busy    <= (INIT_CLEAR != 0);
    end else if (state == CLEAR) begin
      clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
      if (clr_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
        state <= IDLE;
        busy  <= 1'b0;
      end
    end
  end

  // Storage is never reset; only the clear sequencer zeroes it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clearing) begin
        mem[clr_cnt] <= '0;
      end else if (wr_acc) begin
        for (int i = 0; i < LANES; i++) begin
          if (be[i]) begin
            mem[waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <=
              data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
          end
        end
      end
    end
  end

  // Write-through merges only the enabled lanes of the colliding write.
  always_comb begin
    rd_word = old_word;
    if ((RDW_MODE != 0) && hit) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) begin
          rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] =
            data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
      s1_coll  <= 1'b0;
    end else begin
      s1_valid <= rd_acc;
      s1_coll  <= hit;
      if (rd_acc) begin
        s1_data <= rd_word;
      end
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    always_ff @(posedge clk) begin
      if (rst) begin
        data_out  <= '0;
        rvalid    <= 1'b0;
        collision <= 1'b0;
      end else begin
        rvalid    <= s1_valid;
        collision <= s1_coll;
        if (s1_valid) begin
          data_out <= s1_data;
        end
      end
    end
  end else begin : g_noreg
    assign data_out  = s1_data;
    assign rvalid    = s1_valid;
    assign collision = s1_coll;
  end

endmodule

// File: tb/tb_dpram_param_sync.sv
// Bench for dpram_param_sync: an 8-bit old-data instance and a 32-bit
// write-through instance with output register, driven by shared stimulus.
module tb_dpram_param_sync;

  logic        clk = 1'b0;
  logic        rst;
  logic        wen;
  logic        ren;
  logic [6:0]  waddr;
  logic [6:0]  raddr;
  logic [31:0] data_in;
  logic [3:0]  be;

  logic [7:0]  dout_a;
  logic        rv_a, col_a, busy_a;
  logic [31:0] dout_b;
  logic        rv_b, col_b, busy_b;

  always #5 clk = ~clk;

  dpram_param_sync #(
    .DATA_WIDTH(8), .ADDR_WIDTH(7), .BYTE_WIDTH(8),
    .OUT_REG(0), .RDW_MODE(0), .INIT_CLEAR(1)
  ) u_a (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr),
    .data_in(data_in[7:0]), .be(be[0:0]), .ren(ren), .raddr(raddr),
    .data_out(dout_a), .rvalid(rv_a), .collision(col_a), .busy(busy_a)
  );

  dpram_param_sync #(
    .DATA_WIDTH(32), .ADDR_WIDTH(7), .BYTE_WIDTH(8),
    .OUT_REG(1), .RDW_MODE(1), .INIT_CLEAR(1)
  ) u_b (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr),
    .data_in(data_in), .be(be), .ren(ren), .raddr(raddr),
    .data_out(dout_b), .rvalid(rv_b), .collision(col_b), .busy(busy_b)
  );

  typedef struct {
    logic [31:0] data;
    logic        coll;
    int          due;
  } exp_t;

  typedef struct {
    logic        wen;
    logic [6:0]  waddr;
    logic [31:0] din;
    logic [3:0]  be;
    logic        ren;
    logic [6:0]  raddr;
    logic [7:0]  ea;
    logic [31:0] eb;
    logic        coll;
  } vec_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea_e;
  exp_t eb_e;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)",
                  name, act, exp, cyc);
  endtask

  // Scoreboard: every read result is matched against its queued expectation.
  always @(negedge clk) begin
    if (rv_a === 1'b1) begin
      if (qa.size() == 0) chk("a_spurious_rvalid", {31'b0, rv_a}, 32'd0);
      else begin
        ea_e = qa.pop_front();
        chk("a_data", {24'b0, dout_a}, ea_e.data);
        chk("a_coll", {31'b0, col_a}, {31'b0, ea_e.coll});
        chk("a_latency", 32'(cyc), 32'(ea_e.due));
      end
    end else if (qa.size() != 0 && qa[0].due <= cyc) begin
      void'(qa.pop_front());
      chk("a_missing_rvalid", {31'b0, rv_a}, 32'd1);
    end
    if (rv_b === 1'b1) begin
      if (qb.size() == 0) chk("b_spurious_rvalid", {31'b0, rv_b}, 32'd0);
      else begin
        eb_e = qb.pop_front();
        chk("b_data", dout_b, eb_e.data);
        chk("b_coll", {31'b0, col_b}, {31'b0, eb_e.coll});
        chk("b_latency", 32'(cyc), 32'(eb_e.due));
      end
    end else if (qb.size() != 0 && qb[0].due <= cyc) begin
      void'(qb.pop_front());
      chk("b_missing_rvalid", {31'b0, rv_b}, 32'd1);
    end
  end

  task automatic drive(input logic w, input logic [6:0] wa,
                       input logic [31:0] d, input logic [3:0] b,
                       input logic r, input logic [6:0] ra,
                       input logic [31:0] ea, input logic [31:0] eb,
                       input logic c);
    wen = w; waddr = wa; data_in = d; be = b; ren = r; raddr = ra;
    @(posedge clk); #1;
    if (r) begin
      qa.push_back('{ea, c, cyc});
      qb.push_back('{eb, c, cyc + 1});
    end
    wen = 1'b0; ren = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic noise();
    wen = 1'b1; waddr = 7'd3; data_in = 32'h7777_7777; be = 4'hF;
    ren = 1'b1; raddr = 7'($urandom_range(0, 127));
  endtask

  task automatic wait_clear(input bit nz, output int na, output int nb);
    na = 0; nb = 0;
    for (int k = 1; k <= 300 && (na == 0 || nb == 0); k++) begin
      if (nz) noise();
      @(posedge clk); #1;
      if (na == 0 && busy_a === 1'b0) na = k;
      if (nb == 0 && busy_b === 1'b0) nb = k;
    end
    wen = 1'b0; ren = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_dout_a"}, {24'b0, dout_a}, 32'd0);
    chk({tag, "_rv_a"}, {31'b0, rv_a}, 32'd0);
    chk({tag, "_col_a"}, {31'b0, col_a}, 32'd0);
    chk({tag, "_busy_a"}, {31'b0, busy_a}, 32'd1);
    chk({tag, "_dout_b"}, dout_b, 32'd0);
    chk({tag, "_rv_b"}, {31'b0, rv_b}, 32'd0);
    chk({tag, "_col_b"}, {31'b0, col_b}, 32'd0);
    chk({tag, "_busy_b"}, {31'b0, busy_b}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[14];
    int   na, nb;

    vt[0]  = '{1'b1, 7'd5,  32'h1111_11A5, 4'hF, 1'b0, 7'd0,  8'h00, 32'h0, 1'b0};
    vt[1]  = '{1'b0, 7'd0,  32'h0,         4'h0, 1'b1, 7'd5,  8'hA5, 32'h1111_11A5, 1'b0};
    vt[2]  = '{1'b1, 7'd9,  32'h0000_0011, 4'hF, 1'b0, 7'd0,  8'h00, 32'h0, 1'b0};
    vt[3]  = '{1'b1, 7'd9,  32'h2222_2222, 4'hF, 1'b1, 7'd9,  8'h11, 32'h2222_2222, 1'b1};
    vt[4]  = '{1'b0, 7'd0,  32'h0,         4'h0, 1'b1, 7'd9,  8'h22, 32'h2222_2222, 1'b0};
    vt[5]  = '{1'b1, 7'd3,  32'hFFFF_FFFF, 4'hF, 1'b0, 7'd0,  8'h00, 32'h0, 1'b0};
    vt[6]  = '{1'b1, 7'd3,  32'h7856_3412, 4'h5, 1'b0, 7'd0,  8'h00, 32'h0, 1'b0};
    vt[7]  = '{1'b0, 7'd0,  32'h0,         4'h0, 1'b1, 7'd3,  8'h12, 32'hFF56_FF12, 1'b0};
    vt[8]  = '{1'b1, 7'd4,  32'hAABB_CCDD, 4'h0, 1'b0, 7'd0,  8'h00, 32'h0, 1'b0};
    vt[9]  = '{1'b0, 7'd0,  32'h0,         4'h0, 1'b1, 7'd4,  8'h00, 32'h0, 1'b0};
    vt[10] = '{1'b1, 7'd3,  32'h9900_EE77, 4'h2, 1'b1, 7'd3,  8'h12, 32'hFF56_EE12, 1'b1};
    vt[11] = '{1'b0, 7'd0,  32'h0,         4'h0, 1'b1, 7'd3,  8'h12, 32'hFF56_EE12, 1'b0};
    vt[12] = '{1'b1, 7'd10, 32'h3C3C_3C3C, 4'hF, 1'b1, 7'd11, 8'h00, 32'h0, 1'b0};
    vt[13] = '{1'b0, 7'd0,  32'h0,         4'h0, 1'b1, 7'd10, 8'h3C, 32'h3C3C_3C3C, 1'b0};

    rst = 1'b1; wen = 1'b0; ren = 1'b0;
    waddr = '0; raddr = '0; data_in = '0; be = '0;
    @(posedge clk); #1;
    chk_reset("rst0");
    rst = 1'b0;
    wait_clear(1'b0, na, nb);
    chk("clear_len_a", 32'(na), 32'd128);
    chk("clear_len_b", 32'(nb), 32'd128);

    // Fill with nonzero words so the next clear has something to erase.
    for (int a = 0; a < 128; a++) begin
      drive(1'b1, 7'(a), {4{1'b1, 7'(a)}}, 4'hF, 1'b0, 7'd0,
            32'd0, 32'd0, 1'b0);
    end
    idle(2);

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (50) begin noise(); @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midclear_busy_a", {31'b0, busy_a}, 32'd1);
    chk("midclear_busy_b", {31'b0, busy_b}, 32'd1);
    wait_clear(1'b1, na, nb);
    chk("restart_len_a", 32'(na), 32'd128);
    chk("restart_len_b", 32'(nb), 32'd128);

    for (int a = 0; a < 128; a++) begin
      drive(1'b0, 7'd0, 32'd0, 4'h0, 1'b1, 7'(a),
            32'd0, 32'd0, 1'b0);
    end
    idle(4);
    chk("drain1_a", 32'(qa.size()), 32'd0);
    chk("drain1_b", 32'(qb.size()), 32'd0);

    for (int i = 0; i < 14; i++) begin
      drive(vt[i].wen, vt[i].waddr, vt[i].din, vt[i].be,
            vt[i].ren, vt[i].raddr, {24'b0, vt[i].ea}, vt[i].eb,
            vt[i].coll);
    end
    idle(4);
    chk("drain2_a", 32'(qa.size()), 32'd0);
    chk("drain2_b", 32'(qb.size()), 32'd0);

    for (int i = 0; i < 10; i++) begin
      idle(1);
      chk("hold_dout_a", {24'b0, dout_a}, 32'h3C);
      chk("hold_rv_a", {31'b0, rv_a}, 32'd0);
      chk("hold_dout_b", dout_b, 32'h3C3C_3C3C);
      chk("hold_rv_b", {31'b0, rv_b}, 32'd0);
    end

    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset("rst1");
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
